// File: rtl/smpl_circ_queue_pkg.sv
// smpl_q_pkg: shared FSM state type and legal parameter ranges for the sample queue.
package smpl_q_pkg;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    localparam int DEPTH_MIN = 4;
    localparam int DEPTH_MAX = 4096;
    localparam int DECIM_MIN = 1;
    localparam int DECIM_MAX = 4;
endpackage

// File: rtl/smpl_circ_queue_if.sv
// smpl_circ_queue_if: sample strobe in, burst stream and status out.
interface smpl_circ_queue_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1536
);
    localparam int PTR_W = $clog2(DEPTH);
    logic             wrt_smpl;
    logic [WIDTH-1:0] new_smpl;
    logic             clr_ovr;
    logic [WIDTH-1:0] smpl_out;
    logic             smpl_vld;
    logic             first;
    logic             last;
    logic             sequencing;
    logic             primed;
    logic [PTR_W:0]   fill_cnt;
    logic             overrun;
    modport master (
        output wrt_smpl, new_smpl, clr_ovr,
        input  smpl_out, smpl_vld, first, last, sequencing, primed, fill_cnt, overrun
    );
    modport slave (
        input  wrt_smpl, new_smpl, clr_ovr,
        output smpl_out, smpl_vld, first, last, sequencing, primed, fill_cnt, overrun
    );
endinterface

// File: rtl/smpl_circ_queue_dp_ram.sv
// dp_ram: one write port, one read port with registered rdata; storage is never reset.
module dp_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1536,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/smpl_circ_queue.sv
// smpl_circ_queue: circular sample store; once full, every accepted sample
// streams all DEPTH stored samples oldest-first, one per clk.
module smpl_circ_queue
    import smpl_q_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1536,
    parameter int DECIM = 1
) (
    input logic clk,
    input logic rst_n,
    smpl_circ_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   FULL      = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   LAST_CNT  = (PTR_W + 1)'(DEPTH - 1);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_chk
        $error("smpl_circ_queue: DEPTH %0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
    end
    if (DECIM < DECIM_MIN || DECIM > DECIM_MAX) begin : g_decim_chk
        $error("smpl_circ_queue: DECIM %0d outside %0d..%0d", DECIM, DECIM_MIN, DECIM_MAX);
    end

    state_t           state, state_nxt;
    logic             seq;
    logic [1:0]       dec_cnt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt;
    logic [PTR_W:0]   fill_cnt, fill_nxt, rd_cnt;
    logic             overrun;
    logic             qual, wr_en, burst, rd_en, rd_done;
    logic             rd_vld, rd_first, rd_last;
    logic [WIDTH-1:0] rdata;

    assign qual       = q.wrt_smpl && dec_cnt == 2'd0;
    assign wr_en      = qual && !seq;
    assign wr_ptr_nxt = wr_ptr == LAST_ADDR ? '0 : wr_ptr + PTR_W'(1);
    assign fill_nxt   = fill_cnt == FULL ? fill_cnt : fill_cnt + (PTR_W + 1)'(1);
    assign burst      = wr_en && fill_nxt == FULL;
    assign rd_done    = rd_cnt == LAST_CNT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            seq   <= 1'b0;
        end else begin
            state <= state_nxt;
            seq   <= state_nxt != IDLE;
        end
    end

    always_comb begin
        state_nxt = state == IDLE ? (burst ? READ : IDLE) :
                    state == READ ? (rd_done ? DRAIN : READ) : IDLE;
        rd_en     = state == READ;
    end

    // The burst starts at the post-write pointer, which is the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt    <= '0;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            overrun    <= 1'b0;
            rd_ptr     <= '0;
            rd_cnt     <= '0;
            rd_vld     <= 1'b0;
            rd_first   <= 1'b0;
            rd_last    <= 1'b0;
            q.smpl_vld <= 1'b0;
            q.first    <= 1'b0;
            q.last     <= 1'b0;
            q.smpl_out <= '0;
        end else begin
            if (q.wrt_smpl) dec_cnt <= dec_cnt == 2'(DECIM - 1) ? 2'd0 : dec_cnt + 2'd1;
            if (wr_en) begin
                wr_ptr   <= wr_ptr_nxt;
                fill_cnt <= fill_nxt;
            end
            overrun    <= (qual && seq) || (overrun && !q.clr_ovr);
            rd_ptr     <= burst ? wr_ptr_nxt : rd_en ? (rd_ptr == LAST_ADDR ? '0 : rd_ptr + PTR_W'(1)) : rd_ptr;
            rd_cnt     <= burst ? '0 : rd_en ? rd_cnt + (PTR_W + 1)'(1) : rd_cnt;
            rd_vld     <= rd_en;
            rd_first   <= rd_en && rd_cnt == '0;
            rd_last    <= rd_en && rd_done;
            q.smpl_vld <= rd_vld;
            q.first    <= rd_first;
            q.last     <= rd_last;
            q.smpl_out <= rd_vld ? rdata : '0;
        end
    end

    assign q.sequencing = seq;
    assign q.fill_cnt   = fill_cnt;
    assign q.primed     = fill_cnt == FULL;
    assign q.overrun    = overrun;

    dp_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (q.new_smpl),
        .re    (rd_en),
        .raddr (rd_ptr),
        .rdata (rdata)
    );
endmodule
